// File: rtl/world_pkg.sv
// Shared robot-world definitions: map geometry, cell and orientation codes,
// scanner state encoding and the neighbour slot selector.
package world_pkg;

  localparam int MAP_ROWS_DEFAULT = 10;
  localparam int MAP_COLS_DEFAULT = 20;

  typedef enum logic [1:0] {
    north = 2'b00,
    south = 2'b01,
    east  = 2'b10,
    west  = 2'b11
  } orientation_t;

  localparam logic [1:0] CELL_FREE    = 2'b00;
  localparam logic [1:0] CELL_WALL    = 2'b01;
  localparam logic [1:0] CELL_GARBAGE = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_UNDER,
    RD_HEAD,
    RD_LEFT,
    CAPTURE
  } scan_state_t;

  typedef enum logic [1:0] {
    SLOT_UNDER,
    SLOT_HEAD,
    SLOT_LEFT
  } slot_t;

  // Map coordinates are 1-based; 0 and anything past the limit are off the map.
  function automatic logic in_range(input logic [5:0] value, input int limit);
    return (int'(value) >= 1) && (int'(value) <= limit);
  endfunction

endpackage

// File: rtl/sensor_scanner_if.sv
// Scan request, map ROM port and sensor result bundle of the sensor scanner.
interface sensor_scanner_if;

  logic       start;
  logic [5:0] robot_row;
  logic [5:0] robot_column;
  logic [1:0] robot_orientation;
  logic [5:0] map_row;
  logic [5:0] map_column;
  logic [1:0] map_cell;
  logic       head;
  logic       left;
  logic       under;
  logic       busy;
  logic       done;

  modport master (
    output start,
    output robot_row,
    output robot_column,
    output robot_orientation,
    output map_cell,
    input  map_row,
    input  map_column,
    input  head,
    input  left,
    input  under,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  robot_row,
    input  robot_column,
    input  robot_orientation,
    input  map_cell,
    output map_row,
    output map_column,
    output head,
    output left,
    output under,
    output busy,
    output done
  );

endinterface

// File: rtl/neighbor_calc.sv
// Combinational neighbour address generator: picks the cell for a scan slot
// and substitutes a legal ROM address when that cell lies off the map.
module neighbor_calc
  import world_pkg::*;
#(
  parameter int MAP_ROWS = MAP_ROWS_DEFAULT,
  parameter int MAP_COLS = MAP_COLS_DEFAULT
) (
  input  logic [5:0]   robot_row,
  input  logic [5:0]   robot_column,
  input  orientation_t orientation,
  input  slot_t        slot,
  output logic [5:0]   row,
  output logic [5:0]   column,
  output logic         out_of_map
);

  logic [5:0] cell_row;
  logic [5:0] cell_column;
  logic       robot_in_map;

  always_comb begin
    cell_row    = robot_row;
    cell_column = robot_column;
    if (slot == SLOT_HEAD) begin
      unique case (orientation)
        north: cell_row    = robot_row - 6'd1;
        south: cell_row    = robot_row + 6'd1;
        east:  cell_column = robot_column + 6'd1;
        west:  cell_column = robot_column - 6'd1;
      endcase
    end else if (slot == SLOT_LEFT) begin
      unique case (orientation)
        north: cell_column = robot_column - 6'd1;
        south: cell_column = robot_column + 6'd1;
        east:  cell_row    = robot_row - 6'd1;
        west:  cell_row    = robot_row + 6'd1;
      endcase
    end
  end

  assign robot_in_map = in_range(robot_row, MAP_ROWS) && in_range(robot_column, MAP_COLS);
  assign out_of_map   = !(in_range(cell_row, MAP_ROWS) && in_range(cell_column, MAP_COLS));

  // Off-map slots still present a legal ROM address; the force flag discards the data.
  assign row    = !out_of_map ? cell_row    : (robot_in_map ? robot_row    : 6'd1);
  assign column = !out_of_map ? cell_column : (robot_in_map ? robot_column : 6'd1);

endmodule

// File: rtl/sensor_scanner.sv
// Reads robot cell, cell ahead and cell to the left from the synchronous map
// ROM and publishes head/left/under together with a one-cycle done pulse.
module sensor_scanner
  import world_pkg::*;
#(
  parameter int MAP_ROWS = MAP_ROWS_DEFAULT,
  parameter int MAP_COLS = MAP_COLS_DEFAULT
) (
  input logic             clock,
  input logic             reset,
  sensor_scanner_if.slave bus
);

  scan_state_t  state_reg;
  scan_state_t  state_next;

  logic [5:0]   latch_row_reg;
  logic [5:0]   latch_column_reg;
  orientation_t latch_orientation_reg;

  logic [5:0]   addr_row_reg;
  logic [5:0]   addr_column_reg;
  logic         force_under_reg;
  logic         force_head_reg;
  logic         force_left_reg;

  logic         under_shadow_reg;
  logic         head_shadow_reg;
  logic         head_reg;
  logic         left_reg;
  logic         under_reg;
  logic         done_reg;

  logic         accept;
  logic         issue;
  logic         capture_under;
  logic         capture_head;
  logic         capture_final;

  logic [5:0]   calc_row_in;
  logic [5:0]   calc_column_in;
  orientation_t calc_orientation;
  slot_t        calc_slot;
  logic [5:0]   calc_row;
  logic [5:0]   calc_column;
  logic         calc_out_of_map;

  logic         cell_is_wall;
  logic         cell_is_garbage;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    accept        = 1'b0;
    issue         = 1'b0;
    capture_under = 1'b0;
    capture_head  = 1'b0;
    capture_final = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = RD_UNDER;
          accept     = 1'b1;
          issue      = 1'b1;
        end
      end
      RD_UNDER: begin
        state_next = RD_HEAD;
        issue      = 1'b1;
      end
      RD_HEAD: begin
        state_next    = RD_LEFT;
        issue         = 1'b1;
        capture_under = 1'b1;
      end
      RD_LEFT: begin
        state_next   = CAPTURE;
        capture_head = 1'b1;
      end
      CAPTURE: begin
        state_next    = IDLE;
        capture_final = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // The robot-cell address is issued on the accepting edge, before the latch holds the inputs.
  always_comb begin
    calc_row_in      = latch_row_reg;
    calc_column_in   = latch_column_reg;
    calc_orientation = latch_orientation_reg;
    calc_slot        = SLOT_UNDER;
    case (state_reg)
      IDLE: begin
        calc_row_in      = bus.robot_row;
        calc_column_in   = bus.robot_column;
        calc_orientation = orientation_t'(bus.robot_orientation);
      end
      RD_UNDER: calc_slot = SLOT_HEAD;
      RD_HEAD:  calc_slot = SLOT_LEFT;
      default:  calc_slot = SLOT_UNDER;
    endcase
  end

  neighbor_calc #(
    .MAP_ROWS (MAP_ROWS),
    .MAP_COLS (MAP_COLS)
  ) u_neighbor_calc (
    .robot_row    (calc_row_in),
    .robot_column (calc_column_in),
    .orientation  (calc_orientation),
    .slot         (calc_slot),
    .row          (calc_row),
    .column       (calc_column),
    .out_of_map   (calc_out_of_map)
  );

  assign cell_is_wall    = (bus.map_cell == CELL_WALL);
  assign cell_is_garbage = (bus.map_cell == CELL_GARBAGE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      latch_row_reg         <= 6'd0;
      latch_column_reg      <= 6'd0;
      latch_orientation_reg <= north;
      addr_row_reg          <= 6'd1;
      addr_column_reg       <= 6'd1;
      force_under_reg       <= 1'b0;
      force_head_reg        <= 1'b0;
      force_left_reg        <= 1'b0;
      under_shadow_reg      <= 1'b0;
      head_shadow_reg       <= 1'b0;
      head_reg              <= 1'b0;
      left_reg              <= 1'b0;
      under_reg             <= 1'b0;
      done_reg              <= 1'b0;
    end else begin
      done_reg <= capture_final;
      if (accept) begin
        latch_row_reg         <= bus.robot_row;
        latch_column_reg      <= bus.robot_column;
        latch_orientation_reg <= orientation_t'(bus.robot_orientation);
      end
      if (issue) begin
        addr_row_reg    <= calc_row;
        addr_column_reg <= calc_column;
        case (calc_slot)
          SLOT_UNDER: force_under_reg <= calc_out_of_map;
          SLOT_HEAD:  force_head_reg  <= calc_out_of_map;
          default:    force_left_reg  <= calc_out_of_map;
        endcase
      end
      // ROM data trails its address by one edge, so each capture uses the previous slot's flag.
      if (capture_under) begin
        under_shadow_reg <= cell_is_garbage && !force_under_reg;
      end
      if (capture_head) begin
        head_shadow_reg <= cell_is_wall || force_head_reg;
      end
      if (capture_final) begin
        head_reg  <= head_shadow_reg;
        left_reg  <= cell_is_wall || force_left_reg;
        under_reg <= under_shadow_reg;
      end
    end
  end

  assign bus.map_row    = addr_row_reg;
  assign bus.map_column = addr_column_reg;
  assign bus.head       = head_reg;
  assign bus.left       = left_reg;
  assign bus.under      = under_reg;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.done       = done_reg;

endmodule

// File: tb/tb_sensor_scanner.sv
// Self-checking bench for sensor_scanner: ROM model, cycle-level behavioural
// reference, directed scenarios and randomized scans.
module tb_sensor_scanner;
  import world_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  sensor_scanner_if bus();

  sensor_scanner #(
    .MAP_ROWS (10),
    .MAP_COLS (20)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [1:0] map_mem [0:63][0:63];

  always @(posedge clock) bus.map_cell <= map_mem[bus.map_row][bus.map_column];

  int tests       = 0;
  int fails       = 0;
  int fail_prints = 0;
  int done_seen   = 0;
  int accepted    = 0;

  typedef struct packed {
    logic [5:0] r0, c0, r1, c1, r2, c2;
    logic       h, l, u;
  } scan_t;

  function automatic bit on_map(int r, int c);
    return (r >= 1) && (r <= 10) && (c >= 1) && (c <= 20);
  endfunction

  // Expected addresses and sensor bits of one scan, straight from the neighbour table.
  function automatic scan_t model_scan(int r, int c, int o);
    int hdr, hdc, ldr, ldc, hr, hc, lr, lc, fr, fc;
    scan_t s;
    case (o)
      0:       begin hdr = -1; hdc =  0; ldr =  0; ldc = -1; end
      1:       begin hdr =  1; hdc =  0; ldr =  0; ldc =  1; end
      2:       begin hdr =  0; hdc =  1; ldr = -1; ldc =  0; end
      default: begin hdr =  0; hdc = -1; ldr =  1; ldc =  0; end
    endcase
    hr = (r + hdr + 64) % 64;
    hc = (c + hdc + 64) % 64;
    lr = (r + ldr + 64) % 64;
    lc = (c + ldc + 64) % 64;
    fr = on_map(r, c) ? r : 1;
    fc = on_map(r, c) ? c : 1;
    s.r0 = 6'(fr);
    s.c0 = 6'(fc);
    s.u  = on_map(r, c) && (map_mem[r][c] == CELL_GARBAGE);
    if (on_map(hr, hc)) begin
      s.r1 = 6'(hr); s.c1 = 6'(hc); s.h = (map_mem[hr][hc] == CELL_WALL);
    end else begin
      s.r1 = 6'(fr); s.c1 = 6'(fc); s.h = 1'b1;
    end
    if (on_map(lr, lc)) begin
      s.r2 = 6'(lr); s.c2 = 6'(lc); s.l = (map_mem[lr][lc] == CELL_WALL);
    end else begin
      s.r2 = 6'(fr); s.c2 = 6'(fc); s.l = 1'b1;
    end
    return s;
  endfunction

  int         m_phase = 0;
  logic       m_busy  = 1'b0;
  logic       m_done  = 1'b0;
  logic       m_h     = 1'b0;
  logic       m_l     = 1'b0;
  logic       m_u     = 1'b0;
  logic [5:0] m_row   = 6'd1;
  logic [5:0] m_col   = 6'd1;
  scan_t      m_scan;

  // Reference: a scan occupies five edges, addresses follow the slot order.
  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      m_phase = 0; m_busy = 1'b0; m_done = 1'b0;
      m_h = 1'b0; m_l = 1'b0; m_u = 1'b0;
      m_row = 6'd1; m_col = 6'd1;
    end else begin
      m_done = 1'b0;
      if (m_phase == 0) begin
        if (bus.start === 1'b1) begin
          m_scan = model_scan(int'(bus.robot_row), int'(bus.robot_column), int'(bus.robot_orientation));
          m_phase = 1;
          m_row = m_scan.r0; m_col = m_scan.c0;
          accepted++;
        end
      end else begin
        m_phase++;
        if (m_phase == 2) begin
          m_row = m_scan.r1; m_col = m_scan.c1;
        end else if (m_phase == 3) begin
          m_row = m_scan.r2; m_col = m_scan.c2;
        end else if (m_phase == 5) begin
          m_phase = 0; m_done = 1'b1;
          m_h = m_scan.h; m_l = m_scan.l; m_u = m_scan.u;
        end
      end
      m_busy = (m_phase != 0);
    end
  end

  initial forever begin
    @(negedge clock);
    tests++;
    if ({bus.busy, bus.done, bus.head, bus.left, bus.under, bus.map_row, bus.map_column} !==
        {m_busy, m_done, m_h, m_l, m_u, m_row, m_col}) begin
      fails++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("FAIL cycle t=%0t: busy/done/head/left/under/row/col got %b/%b/%b/%b/%b/%0d/%0d required %b/%b/%b/%b/%b/%0d/%0d",
                 $time, bus.busy, bus.done, bus.head, bus.left, bus.under, bus.map_row, bus.map_column,
                 m_busy, m_done, m_h, m_l, m_u, m_row, m_col);
      end
    end
    if (bus.done === 1'b1) done_seen++;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic randomize_map();
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        map_mem[r][c] = 2'($urandom_range(0, 3));
  endtask

  // Launches one scan from an idle DUT and checks addresses, done latency and results.
  task automatic run_scan(input string name, input int r, input int c, input int o, input bit perturb,
                          input int er0, input int ec0, input int er1, input int ec1,
                          input int er2, input int ec2, input int eh, input int el, input int eu);
    int   ar[3];
    int   ac[3];
    int   done_at;
    logic h, l, u;
    done_at = -1; h = 1'b0; l = 1'b0; u = 1'b0;
    bus.start = 1'b1;
    bus.robot_row = 6'(r); bus.robot_column = 6'(c); bus.robot_orientation = 2'(o);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (k < 3) begin
        ar[k] = int'(bus.map_row);
        ac[k] = int'(bus.map_column);
      end
      if (bus.done === 1'b1 && done_at < 0) begin
        done_at = k; h = bus.head; l = bus.left; u = bus.under;
      end
      #1;
      bus.start = 1'b0;
      if (perturb && k == 0) begin
        bus.robot_row = 6'd2; bus.robot_column = 6'd2; bus.robot_orientation = 2'd3;
      end
    end
    check({name, " addr under"}, ar[0] * 64 + ac[0], er0 * 64 + ec0);
    check({name, " addr head"},  ar[1] * 64 + ac[1], er1 * 64 + ec1);
    check({name, " addr left"},  ar[2] * 64 + ac[2], er2 * 64 + ec2);
    check({name, " done latency"}, done_at, 4);
    check({name, " head"},  int'(h), eh);
    check({name, " left"},  int'(l), el);
    check({name, " under"}, int'(u), eu);
    $display("[TB] scan %s (%0d,%0d) o=%0d: head=%0d left=%0d under=%0d done_at=%0d", name, r, c, o, h, l, u, done_at);
  endtask

  initial begin
    int d;
    int acc0;
    bus.start = 1'b0;
    bus.robot_row = 6'd0; bus.robot_column = 6'd0; bus.robot_orientation = 2'd0;
    randomize_map();
    map_mem[4][7]   = CELL_WALL;
    map_mem[5][7]   = CELL_GARBAGE;
    map_mem[5][6]   = CELL_FREE;
    map_mem[1][1]   = CELL_GARBAGE;
    map_mem[9][20]  = CELL_FREE;
    map_mem[10][20] = CELL_GARBAGE;

    repeat (2) @(negedge clock);
    check("reset flags", int'({bus.busy, bus.done, bus.head, bus.left, bus.under}), 0);
    check("reset address", int'(bus.map_row) * 64 + int'(bus.map_column), 65);
    #1 reset = 1'b0;
    @(negedge clock); #1;

    run_scan("north_5_7",   5,  7, 0, 1'b0,  5,  7,  4,  7,  5,  6, 1, 0, 1);
    run_scan("corner_1_1",  1,  1, 0, 1'b0,  1,  1,  1,  1,  1,  1, 1, 1, 1);
    run_scan("east_10_20", 10, 20, 2, 1'b0, 10, 20, 10, 20,  9, 20, 1, 0, 1);
    run_scan("south_10_20",10, 20, 1, 1'b0, 10, 20, 10, 20, 10, 20, 1, 1, 1);
    run_scan("perturbed",   5,  7, 0, 1'b1,  5,  7,  4,  7,  5,  6, 1, 0, 1);

    // Reset during RD_HEAD wipes the previous results and suppresses done.
    bus.start = 1'b1; bus.robot_row = 6'd5; bus.robot_column = 6'd7; bus.robot_orientation = 2'd0;
    @(negedge clock); #1 bus.start = 1'b0;
    @(negedge clock); #1 reset = 1'b1;
    @(negedge clock);
    check("midscan reset flags", int'({bus.busy, bus.done, bus.head, bus.left, bus.under}), 0);
    check("midscan reset address", int'(bus.map_row) * 64 + int'(bus.map_column), 65);
    #1 reset = 1'b0;
    d = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (bus.done === 1'b1) d++;
      #1;
    end
    check("midscan reset no done", d, 0);
    $display("[TB] reset mid-scan: dones after reset=%0d", d);

    // Continuous start: one done every five cycles.
    d = 0; acc0 = accepted;
    bus.start = 1'b1; bus.robot_row = 6'd3; bus.robot_column = 6'd4; bus.robot_orientation = 2'd2;
    for (int k = 0; k < 25; k++) begin
      @(negedge clock);
      if (bus.done === 1'b1) d++;
      #1;
      bus.robot_row = 6'($urandom_range(0, 11));
      bus.robot_column = 6'($urandom_range(0, 21));
      bus.robot_orientation = 2'($urandom_range(0, 3));
    end
    bus.start = 1'b0;
    check("held start done count", d, 5);
    check("held start accepted", accepted - acc0, 5);
    $display("[TB] held start: dones=%0d accepted=%0d", d, accepted - acc0);

    // Start asserted while busy is ignored.
    d = 0;
    bus.start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (bus.done === 1'b1) d++;
      #1;
      bus.start = (k >= 1 && k <= 3);
    end
    check("start during busy done count", d, 1);
    $display("[TB] start during busy: dones=%0d", d);

    randomize_map();
    for (int i = 0; i < 600; i++) begin
      @(negedge clock); #1;
      reset = ($urandom_range(0, 149) == 0);
      bus.start = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) begin
        bus.robot_row = 6'($urandom_range(0, 63));
        bus.robot_column = 6'($urandom_range(0, 63));
      end else begin
        bus.robot_row = 6'($urandom_range(0, 11));
        bus.robot_column = 6'($urandom_range(0, 21));
      end
      bus.robot_orientation = 2'($urandom_range(0, 3));
    end
    reset = 1'b0;
    bus.start = 1'b0;
    repeat (8) @(negedge clock);
    $display("[TB] random phase: accepted=%0d dones=%0d", accepted, done_seen);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
